first_four_demux: RTL and testbench

- Registered 1-to-4 demultiplexer: routes data input `a` to one of four outputs (b, c, d, e) selected by the 2-bit code {s1, s0}.
- Non-selected outputs are driven to zero.
- Sits between a single producer and four consumer lanes; one-cycle registered latency gives clean, glitch-free lane outputs.

---
 rtl/first_four_demux.sv | 79 +++++++
 tb/tb_first_four_demux.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/first_four_demux.sv
// Registered 1-to-4 demultiplexer: routes a to lane {s1,s0} one cycle later, zeroing the others.
// Define FOUR_DEMUX_STATS_EN to add saturating per-lane hit counters with a synchronous clear.
module first_four_demux #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic             s0,
  input  logic             s1,
  input  logic             in_valid,
`ifdef FOUR_DEMUX_STATS_EN
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] hit_b,
  output logic [CNT_W-1:0] hit_c,
  output logic [CNT_W-1:0] hit_d,
  output logic [CNT_W-1:0] hit_e,
`endif
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] e,
  output logic [3:0]       out_valid
);

  logic [1:0]       w_sel;
  logic [WIDTH-1:0] r_b, r_c, r_d, r_e;
  logic [3:0]       r_out_valid;

  assign w_sel = {s1, s0};

  // Every lane is recomputed each edge, so an unselected lane never holds stale data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_b         <= '0;
      r_c         <= '0;
      r_d         <= '0;
      r_e         <= '0;
      r_out_valid <= 4'b0000;
    end else begin
      r_b         <= (in_valid && (w_sel == 2'd0)) ? a : '0;
      r_c         <= (in_valid && (w_sel == 2'd1)) ? a : '0;
      r_d         <= (in_valid && (w_sel == 2'd2)) ? a : '0;
      r_e         <= (in_valid && (w_sel == 2'd3)) ? a : '0;
      r_out_valid <= in_valid ? (4'b0001 << w_sel) : 4'b0000;
    end
  end

  assign b         = r_b;
  assign c         = r_c;
  assign d         = r_d;
  assign e         = r_e;
  assign out_valid = r_out_valid;

`ifdef FOUR_DEMUX_STATS_EN
  logic [CNT_W-1:0] r_hit [4];

  // Clear wins over a coincident hit; counters stick at all-ones.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) r_hit[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (cnt_clr)
          r_hit[i] <= '0;
        else if (in_valid && (w_sel == i[1:0]) && (r_hit[i] != '1))
          r_hit[i] <= r_hit[i] + CNT_W'(1);
      end
    end
  end

  assign hit_b = r_hit[0];
  assign hit_c = r_hit[1];
  assign hit_d = r_hit[2];
  assign hit_e = r_hit[3];
`endif

endmodule

// File: tb/tb_first_four_demux.sv
// Self-checking bench for first_four_demux: directed test-plan cases then randomized traffic,
// checked against a per-cycle reference model. Stats checks compile in with FOUR_DEMUX_STATS_EN.
module tb_first_four_demux;

  localparam int CNT_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic       clk = 1'b0;
  logic       rst_n, s0, s1, in_valid, cnt_clr;
  logic [0:0] a1;
  logic [7:0] a8;
  logic [0:0] b1, c1, d1, e1;
  logic [7:0] b8, c8, d8, e8;
  logic [3:0] ov1, ov8;
`ifdef FOUR_DEMUX_STATS_EN
  logic [CNT_W-1:0] hb1, hc1, hd1, he1;
  logic [CNT_W-1:0] hb8, hc8, hd8, he8;
`endif

  int tests  = 0;
  int errors = 0;
  int model_cnt [4];

  always #5 clk = ~clk;

  first_four_demux #(.WIDTH(1), .CNT_W(CNT_W)) dut1 (
    .clk(clk), .rst_n(rst_n), .a(a1), .s0(s0), .s1(s1), .in_valid(in_valid),
`ifdef FOUR_DEMUX_STATS_EN
    .cnt_clr(cnt_clr), .hit_b(hb1), .hit_c(hc1), .hit_d(hd1), .hit_e(he1),
`endif
    .b(b1), .c(c1), .d(d1), .e(e1), .out_valid(ov1)
  );

  first_four_demux #(.WIDTH(8), .CNT_W(CNT_W)) dut8 (
    .clk(clk), .rst_n(rst_n), .a(a8), .s0(s0), .s1(s1), .in_valid(in_valid),
`ifdef FOUR_DEMUX_STATS_EN
    .cnt_clr(cnt_clr), .hit_b(hb8), .hit_c(hc8), .hit_d(hd8), .hit_e(he8),
`endif
    .b(b8), .c(c8), .d(d8), .e(e8), .out_valid(ov8)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, predict from the rules, then check just after the edge.
  task automatic step(input logic rn, input logic iv, input logic [1:0] sel,
                      input logic [7:0] av, input logic clr);
    logic [7:0] exp8 [4];
    logic [7:0] got8 [4];
    logic [0:0] got1 [4];
    logic [3:0] exp_ov;
    rst_n = rn; in_valid = iv; {s1, s0} = sel; a8 = av; a1 = av[0]; cnt_clr = clr;
    if (iv && $isunknown(sel)) begin
      errors++;
      $display("FAIL illegal_sel: select is unknown while in_valid=1 at %0t", $time);
    end
    for (int i = 0; i < 4; i++) exp8[i] = (rn && iv && sel == i) ? av : 8'h00;
    exp_ov = (rn && iv) ? (4'b0001 << sel) : 4'b0000;
    for (int i = 0; i < 4; i++) begin
      if (!rn || clr) model_cnt[i] = 0;
      else if (iv && sel == i && model_cnt[i] < CNT_MAX) model_cnt[i]++;
    end
    @(posedge clk);
    #1;
    got8 = '{b8, c8, d8, e8};
    got1 = '{b1, c1, d1, e1};
    check("ov_w8", ov8, exp_ov);
    check("ov_w1", ov1, exp_ov);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("lane%0d_w8", i), got8[i], exp8[i]);
      check($sformatf("lane%0d_w1", i), got1[i], exp8[i][0]);
    end
    check("onehot_ov", ($countones(ov8) <= 1), 1);
`ifdef FOUR_DEMUX_STATS_EN
    check("hit_b", hb8, model_cnt[0]);
    check("hit_c", hc8, model_cnt[1]);
    check("hit_d", hd8, model_cnt[2]);
    check("hit_e", he8, model_cnt[3]);
    check("hit_b_w1", hb1, model_cnt[0]);
`endif
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; s0 = 1'b0; s1 = 1'b0;
    a1 = '0; a8 = '0; cnt_clr = 1'b0;
    for (int i = 0; i < 4; i++) model_cnt[i] = 0;
    @(posedge clk);
    #1;

    // Reset held two clocks under active stimulus
    step(1'b0, 1'b1, 2'b11, 8'h01, 1'b0);
    step(1'b0, 1'b1, 2'b11, 8'h01, 1'b0);

    // Sweep {s1,s0,a}
    for (int k = 0; k < 8; k++) begin
      logic [2:0] kv;
      kv = 3'(k);
      step(1'b1, 1'b1, kv[2:1], {7'h00, kv[0]}, 1'b0);
    end

    // Gating
    step(1'b1, 1'b0, 2'b10, 8'h01, 1'b0);

    // Mid-traffic reset
    repeat (3) step(1'b1, 1'b1, 2'b01, 8'h01, 1'b0);
    step(1'b0, 1'b1, 2'b01, 8'h01, 1'b0);

    // Wide data
    step(1'b1, 1'b1, 2'b11, 8'hA5, 1'b0);
    step(1'b1, 1'b1, 2'b00, 8'h00, 1'b0);

    // Counter saturation on lane b, then clear coinciding with a hit
    step(1'b0, 1'b0, 2'b00, 8'h00, 1'b0);
    step(1'b1, 1'b1, 2'b01, 8'h3C, 1'b0);
    repeat (5) step(1'b1, 1'b1, 2'b00, 8'h01, 1'b0);
    step(1'b1, 1'b1, 2'b00, 8'h01, 1'b1);

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      logic rn, iv, clr;
      logic [1:0] sel;
      logic [7:0] av;
      rn  = ($urandom_range(0, 29) != 0);
      iv  = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 19) == 0);
      sel = 2'($urandom_range(0, 3));
      av  = 8'($urandom);
      step(rn, iv, sel, av, clr);
    end

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
